// File: rtl/thermal_pkg.sv
// Shared definitions for the room thermal plant model: mode encoding,
// default geometry, and small helpers used by the datapath.
package thermal_pkg;

   // Plant operating modes, decoded from the controller's {heating, cooling}
   typedef enum logic [1:0] {
      ST_DRIFT = 2'd0,
      ST_HEAT  = 2'd1,
      ST_COOL  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam int DEF_WIDTH   = 5;
   localparam int DEF_AMBIENT = 20;

   // Map the two command lines onto a plant mode
   function automatic state_t decode_mode(input logic heating, input logic cooling);
      state_t mode;
      case ({heating, cooling})
         2'b10:   mode = ST_HEAT;
         2'b01:   mode = ST_COOL;
         2'b11:   mode = ST_FAULT;
         default: mode = ST_DRIFT;
      endcase
      return mode;
   endfunction

   // Saturate a forced value into the legal temperature range
   function automatic int clamp_temp(input int value, input int lo, input int hi);
      int result;
      result = value;
      if (value < lo) result = lo;
      if (value > hi) result = hi;
      return result;
   endfunction

endpackage : thermal_pkg

// File: rtl/step_timer.sv
// Free-running step counter. It counts edges within the current mode and
// raises a terminal-count pulse on the edge where a temperature step is due.
// The period is STEP_CYCLES while heating/cooling and DRIFT_CYCLES while idle.
module step_timer #(
   parameter int STEP_CYCLES  = 4,
   parameter int DRIFT_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_drift_sel,
   output logic o_tc
);

   localparam int MAX_PERIOD = (STEP_CYCLES > DRIFT_CYCLES) ? STEP_CYCLES : DRIFT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_PERIOD);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_last;

   // Terminal value for the selected period; a clear suppresses the pulse
   // so a mode change or load never steps on the same edge.
   assign w_last = i_drift_sel ? CNT_W'(DRIFT_CYCLES - 1) : CNT_W'(STEP_CYCLES - 1);
   assign o_tc   = !i_clear && (r_count == w_last);

   // Count edges, wrapping to zero at terminal count or on a clear
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear || o_tc) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule : step_timer

// File: rtl/room_temp_model.sv
// Thermal plant model closing the loop around the air-conditioning
// controller: ramps up under heat, down under cool, drifts toward ambient
// when idle, and flags a fault when both commands are asserted together.
module room_temp_model
   import thermal_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int STEP_CYCLES  = 4,
   parameter int DRIFT_CYCLES = 8,
   parameter int AMBIENT      = DEF_AMBIENT,
   parameter int INIT_TEMP    = 20,
   parameter int T_MIN        = 0,
   parameter int T_MAX        = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             heating,
   input  logic             cooling,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] temperature,
   output logic             temp_changed,
   output logic             at_limit,
   output logic             fault
);

   localparam logic [WIDTH-1:0] C_MIN     = WIDTH'(T_MIN);
   localparam logic [WIDTH-1:0] C_MAX     = WIDTH'(T_MAX);
   localparam logic [WIDTH-1:0] C_AMB     = WIDTH'(AMBIENT);
   localparam logic [WIDTH-1:0] C_INIT    = WIDTH'(INIT_TEMP);
   localparam logic [WIDTH:0]   C_MAX_EXT = (WIDTH + 1)'(T_MAX);

   state_t           r_state;
   logic [WIDTH-1:0] r_temp;
   logic             r_temp_changed;
   logic             r_fault;

   state_t           w_next_state;
   logic             w_mode_change;
   logic             w_clear;
   logic             w_tc;
   logic [WIDTH:0]   w_inc;
   logic [WIDTH:0]   w_dec;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_temp_next;

   // Decode the requested mode and detect a mode transition
   assign w_next_state  = decode_mode(heating, cooling);
   assign w_mode_change = (w_next_state != r_state);

   // The counter restarts on a mode change or load, and sits at zero in FAULT
   assign w_clear = load || w_mode_change || (w_next_state == ST_FAULT);

   step_timer #(
      .STEP_CYCLES (STEP_CYCLES),
      .DRIFT_CYCLES(DRIFT_CYCLES)
   ) u_step_timer (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_clear),
      .i_drift_sel(r_state == ST_DRIFT),
      .o_tc       (w_tc)
   );

   // Neighbouring values carry one extra bit so a bound check never sees a wrap
   assign w_inc          = {1'b0, r_temp} + 1'b1;
   assign w_dec          = {1'b0, r_temp} - 1'b1;
   assign w_load_clamped = WIDTH'(clamp_temp(int'(load_value), T_MIN, T_MAX));

   // Next temperature: a load wins, otherwise step on terminal count by mode
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      w_temp_next = r_temp;
      if (load) begin
         w_temp_next = w_load_clamped;
      end else if (w_tc) begin
         case (r_state)
            ST_HEAT: begin
               if (w_inc <= C_MAX_EXT) w_temp_next = w_inc[WIDTH-1:0];
            end
            ST_COOL: begin
               if (!w_dec[WIDTH] && (r_temp > C_MIN)) w_temp_next = w_dec[WIDTH-1:0];
            end
            ST_DRIFT: begin
               if (r_temp < C_AMB) begin
                  w_temp_next = w_inc[WIDTH-1:0];
               end else if (r_temp > C_AMB) begin
                  w_temp_next = w_dec[WIDTH-1:0];
               end
            end
            default: w_temp_next = r_temp;
         endcase
      end
   end

   // Mode FSM with registered temperature, change pulse and fault flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_DRIFT;
         r_temp         <= C_INIT;
         r_temp_changed <= 1'b0;
         r_fault        <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_temp         <= w_temp_next;
         r_temp_changed <= (w_temp_next != r_temp);
         r_fault        <= (w_next_state == ST_FAULT);
      end
   end

   assign temperature  = r_temp;
   assign temp_changed = r_temp_changed;
   assign fault        = r_fault;
   assign at_limit     = (r_temp == C_MIN) || (r_temp == C_MAX);

endmodule : room_temp_model

// File: tb/tb_room_temp_model.sv
// Directed bench for room_temp_model with default parameters. Inputs are
// driven 1 time unit after each rising edge and outputs sampled there too.
module tb_room_temp_model;

   logic       clk;
   logic       rst;
   logic       heating;
   logic       cooling;
   logic       load;
   logic [4:0] load_value;
   logic [4:0] temperature;
   logic       temp_changed;
   logic       at_limit;
   logic       fault;

   int n_checks = 0;
   int n_fails  = 0;

   room_temp_model dut (
      .clk         (clk),
      .rst         (rst),
      .heating     (heating),
      .cooling     (cooling),
      .load        (load),
      .load_value  (load_value),
      .temperature (temperature),
      .temp_changed(temp_changed),
      .at_limit    (at_limit),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold at hold_val for n_hold edges, then expect new_val on the next edge
   task automatic step_expect(input string tag, input int n_hold,
                              input logic [4:0] hold_val, input logic [4:0] new_val);
      for (int i = 0; i < n_hold; i++) begin
         tick();
         check({tag, "_hold"}, temperature, hold_val);
         check({tag, "_hold_pulse"}, temp_changed, 1'b0);
      end
      tick();
      check({tag, "_step"}, temperature, new_val);
      check({tag, "_step_pulse"}, temp_changed, (new_val != hold_val));
   endtask

   initial begin
      rst        = 1'b1;
      heating    = 1'b0;
      cooling    = 1'b0;
      load       = 1'b0;
      load_value = '0;
      tick();
      tick();
      check("rst_temp", temperature, 5'd20);
      check("rst_pulse", temp_changed, 1'b0);
      check("rst_fault", fault, 1'b0);
      check("rst_limit", at_limit, 1'b0);

      // 1: heat ramp from reset value, one step per 4 edges
      rst     = 1'b0;
      heating = 1'b1;
      tick();
      check("heat_entry", temperature, 5'd20);
      step_expect("heat_21", 3, 5'd20, 5'd21);
      step_expect("heat_22", 3, 5'd21, 5'd22);
      step_expect("heat_23", 3, 5'd22, 5'd23);

      // 2: load 30, heat into the upper bound and hold there
      load       = 1'b1;
      load_value = 5'd30;
      tick();
      load = 1'b0;
      check("load30", temperature, 5'd30);
      check("load30_pulse", temp_changed, 1'b1);
      check("load30_limit", at_limit, 1'b0);
      step_expect("heat_31", 3, 5'd30, 5'd31);
      check("max_limit", at_limit, 1'b1);
      step_expect("heat_sat", 7, 5'd31, 5'd31);
      check("sat_limit", at_limit, 1'b1);

      // 3: load 25 and go idle, drift down to ambient and stay
      load       = 1'b1;
      load_value = 5'd25;
      heating    = 1'b0;
      tick();
      load = 1'b0;
      check("load25", temperature, 5'd25);
      check("load25_pulse", temp_changed, 1'b1);
      step_expect("drift_24", 7, 5'd25, 5'd24);
      step_expect("drift_23", 7, 5'd24, 5'd23);
      step_expect("drift_22", 7, 5'd23, 5'd22);
      step_expect("drift_21", 7, 5'd22, 5'd21);
      step_expect("drift_20", 7, 5'd21, 5'd20);
      step_expect("drift_amb", 15, 5'd20, 5'd20);

      // 4: cool from 2 into the lower bound without wrapping
      load       = 1'b1;
      load_value = 5'd2;
      cooling    = 1'b1;
      tick();
      load = 1'b0;
      check("load2", temperature, 5'd2);
      step_expect("cool_1", 3, 5'd2, 5'd1);
      check("cool1_limit", at_limit, 1'b0);
      step_expect("cool_0", 3, 5'd1, 5'd0);
      check("min_limit", at_limit, 1'b1);
      step_expect("cool_sat", 7, 5'd0, 5'd0);

      // 5: fault in the middle of a heat ramp, then resume
      load       = 1'b1;
      load_value = 5'd20;
      cooling    = 1'b0;
      heating    = 1'b1;
      tick();
      load = 1'b0;
      check("load20", temperature, 5'd20);
      tick();
      tick();
      cooling = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("fault_flag", fault, 1'b1);
         check("fault_temp", temperature, 5'd20);
      end
      cooling = 1'b0;
      tick();
      check("fault_clear", fault, 1'b0);
      check("fault_exit_temp", temperature, 5'd20);
      step_expect("resume_21", 3, 5'd20, 5'd21);

      // Load is accepted in FAULT; reloading the same value gives no pulse
      cooling = 1'b1;
      tick();
      check("fault_again", fault, 1'b1);
      load       = 1'b1;
      load_value = 5'd22;
      tick();
      check("fault_load", temperature, 5'd22);
      check("fault_load_pulse", temp_changed, 1'b1);
      tick();
      check("same_load", temperature, 5'd22);
      check("same_load_pulse", temp_changed, 1'b0);
      check("same_load_fault", fault, 1'b1);

      // 6: asynchronous reset mid-ramp at 27
      load_value = 5'd27;
      cooling    = 1'b0;
      tick();
      load = 1'b0;
      check("load27", temperature, 5'd27);
      tick();
      tick();
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_temp", temperature, 5'd20);
      check("async_rst_fault", fault, 1'b0);
      check("async_rst_pulse", temp_changed, 1'b0);
      tick();
      rst = 1'b0;
      // Heating is still held: a DRIFT reset state makes this edge a mode entry
      tick();
      check("post_rst_entry", temperature, 5'd20);
      step_expect("post_rst_21", 3, 5'd20, 5'd21);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_room_temp_model

// File: doc/room_temp_model.md
Name: room_temp_model

Overview:
Synthesisable thermal plant model that closes the loop around the air-conditioning controller. It consumes the controller's heating/cooling commands and produces the 5-bit room temperature that the controller senses. Temperature ramps up under heating, ramps down under cooling, and drifts toward ambient when idle. It is used in closed-loop benches and on the board as a stand-in sensor.

Parameters:
WIDTH, 5, temperature width in bits.
STEP_CYCLES, 4, clock cycles per 1-degree step while heating or cooling (must be at least 2).
DRIFT_CYCLES, 8, clock cycles per 1-degree step toward ambient while idle (must be at least 2).
AMBIENT, 20, idle drift target.
INIT_TEMP, 20, temperature at reset.
T_MIN, 0, lower saturation bound.
T_MAX, 31, upper saturation bound.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
heating  input  1  heat command from the controller.
cooling  input  1  cool command from the controller.
load  input  1  one-cycle request to force the temperature.
load_value  input  WIDTH  value to force.
temperature  output  WIDTH  current room temperature, registered.
temp_changed  output  1  one-cycle pulse on every edge where temperature changes value.
at_limit  output  1  high while temperature equals T_MIN or T_MAX.
fault  output  1  high while heating and cooling are both asserted.

Behaviour:
- Reset (async, rst=1): temperature=INIT_TEMP, state=DRIFT, step counter=0, temp_changed=0, fault=0. at_limit follows temperature. Reset mid-ramp discards the partial count.
- State machine. States are DRIFT, HEAT, COOL and FAULT. The next state is decoded every edge from {heating,cooling}:
  - 00 selects DRIFT.
  - 10 selects HEAT.
  - 01 selects COOL.
  - 11 selects FAULT.
- Mode change: on an edge where the decoded state differs from the current state, the state updates, the counter clears to 0 and temperature is unchanged.
- Same mode: the counter increments. When the counter equals PERIOD-1, the counter clears and temperature steps. PERIOD is STEP_CYCLES in HEAT and COOL, and DRIFT_CYCLES in DRIFT.
- Latency: the first step occurs exactly PERIOD edges after the edge that entered the mode. A steady mode then steps every PERIOD edges.
- HEAT steps +1, saturating at T_MAX. COOL steps -1, saturating at T_MIN.
- DRIFT steps one degree toward AMBIENT. There is no step when temperature equals AMBIENT.
- At saturation, or in DRIFT at ambient, the counter keeps running but temperature holds and temp_changed stays 0.
- FAULT: temperature holds, the counter is held at 0 and fault=1 (registered). Leaving FAULT clears fault on the same edge that enters the new state.
- Load: load=1 has priority over stepping.
  - temperature <= load_value, clamped to [T_MIN, T_MAX].
  - Counter clears.
  - State still updates from {heating,cooling}.
  - Load during FAULT is accepted.
- temp_changed: registered. It is 1 on the edge where the temperature register takes a new, different value, including from a load. A load of the current value gives no pulse.
- Arithmetic: +1 and -1 are computed in WIDTH+1 bits and compared against the bounds before writeback. No wrap-around occurs.

Decomposition:
- Shared package thermal_pkg:
  - 2-bit state encoding constants (DRIFT=0, HEAT=1, COOL=2, FAULT=3).
  - Default WIDTH.
  - Default AMBIENT.
- Sub-module step_timer: parameterised free-running counter with clear, run-select between STEP_CYCLES and DRIFT_CYCLES, and a terminal-count pulse output.
- The top level holds the state register, the temperature datapath and the flags.

Test Plan:
1. Reset with defaults, then heating=1 held -> temperature 20 for 4 edges, 21 at the 4th edge after entry, then 22, 23… every 4 edges. temp_changed pulses once per step.
2. load=1 with load_value=30, then heating held -> 31 after 4 edges and at_limit=1. Further edges hold at 31 with no temp_changed pulse.
3. load 25, then idle (00) -> 24 after 8 edges, then 23, 22, 21, 20 at 8-edge intervals, then held at 20 indefinitely.
4. Cooling from 2 -> 1, then 0 with at_limit=1. Cooling held -> stays at 0 with no wrap to 31.
5. heating=cooling=1 for 10 cycles during a HEAT ramp (counter at 2) -> fault=1, temperature frozen. Return to heating -> fault=0, counter restarted, next step 4 edges later.
6. rst pulsed asynchronously mid-ramp at temperature 27 -> temperature=20, fault=0, state DRIFT immediately without waiting for a clock edge. Closed loop with the AC controller -> temperature settles and oscillates within the controller's comfort band.
